// File: rtl/wb_patmos_ctrl.sv
// Wishbone register window that boots Patmos: boot PC, stall/reset and two boot-memory write ports.
// Single-cycle ack after each select (no wait states); back-to-back requests are acked every other cycle.
module wb_patmos_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned BMEM_AW   = 12
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   output logic [31:0]        boot_addr_o,
   output logic               stall_o,
   output logic               core_rst_o,
   output logic [31:0]        bm_odd_dat_o,
   output logic [BMEM_AW-1:0] bm_odd_adr_o,
   output logic               bm_odd_we_o,
   output logic [31:0]        bm_even_dat_o,
   output logic [BMEM_AW-1:0] bm_even_adr_o,
   output logic               bm_even_we_o,
   output logic [31:0]        dbg_o
);

   localparam logic [5:0] W_BOOT     = 6'h00;
   localparam logic [5:0] W_STALL    = 6'h01;
   localparam logic [5:0] W_RESET    = 6'h02;
   localparam logic [5:0] W_ODD_DAT  = 6'h03;
   localparam logic [5:0] W_ODD_ADR  = 6'h04;
   localparam logic [5:0] W_ODD_EN   = 6'h05;
   localparam logic [5:0] W_EVEN_DAT = 6'h06;
   localparam logic [5:0] W_EVEN_ADR = 6'h07;
   localparam logic [5:0] W_EVEN_EN  = 6'h08;
   localparam logic [5:0] W_STATUS   = 6'h09;

   logic               adr_hit;
   logic               sel;
   logic               wr;
   logic               rd;
   logic [5:0]         word;
   logic               unused_adr_lsb;

   logic [31:0]        boot_addr_q;
   logic               stall_q;
   logic               reset_q;
   logic [31:0]        odd_dat_q;
   logic [BMEM_AW-1:0] odd_adr_q;
   logic               odd_en_q;
   logic [31:0]        even_dat_q;
   logic [BMEM_AW-1:0] even_adr_q;
   logic               even_en_q;

   logic               ack_q;
   logic               rd_ack_q;
   logic [31:0]        rd_dat_q;
   logic [31:0]        dbg_q;
   logic               odd_hold_q;
   logic               even_hold_q;

   logic [31:0]        rd_mux;
   logic [BMEM_AW-1:0] odd_adr_nx;
   logic [BMEM_AW-1:0] even_adr_nx;

   function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                               input logic [31:0] dat,
                                               input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? dat[8*i +: 8] : cur[8*i +: 8];
      end
      return res;
   endfunction

   // Byte alignment is irrelevant: a misaligned offset hits its containing word.
   assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};
   assign word           = wbs_adr_i[7:2];
   assign adr_hit        = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign sel            = wbs_cyc_i & wbs_stb_i & adr_hit & ~wbs_ack_o;
   assign wr             = sel & wbs_we_i;
   assign rd             = sel & ~wbs_we_i;

   always_comb begin
      odd_adr_nx  = odd_adr_q;
      even_adr_nx = even_adr_q;
      for (int b = 0; b < int'(BMEM_AW); b++) begin
         if (wbs_sel_i[b/8]) begin
            odd_adr_nx[b]  = wbs_dat_i[b];
            even_adr_nx[b] = wbs_dat_i[b];
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (word)
         W_BOOT:     rd_mux = boot_addr_q;
         W_STALL:    rd_mux = {31'd0, stall_q};
         W_RESET:    rd_mux = {31'd0, reset_q};
         W_ODD_DAT:  rd_mux = odd_dat_q;
         W_ODD_ADR:  rd_mux = {{(32-BMEM_AW){1'b0}}, odd_adr_q};
         W_ODD_EN:   rd_mux = {31'd0, odd_en_q};
         W_EVEN_DAT: rd_mux = even_dat_q;
         W_EVEN_ADR: rd_mux = {{(32-BMEM_AW){1'b0}}, even_adr_q};
         W_EVEN_EN:  rd_mux = {31'd0, even_en_q};
         W_STATUS:   rd_mux = {16'hB007, 14'd0, stall_q, core_rst_o};
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         boot_addr_q <= '0;
         stall_q     <= 1'b0;
         reset_q     <= 1'b1;
         odd_dat_q   <= '0;
         odd_adr_q   <= '0;
         odd_en_q    <= 1'b0;
         even_dat_q  <= '0;
         even_adr_q  <= '0;
         even_en_q   <= 1'b0;
         ack_q       <= 1'b0;
         rd_ack_q    <= 1'b0;
         rd_dat_q    <= '0;
         dbg_q       <= '0;
         odd_hold_q  <= 1'b0;
         even_hold_q <= 1'b0;
      end else begin
         ack_q       <= sel;
         rd_ack_q    <= rd;
         rd_dat_q    <= rd ? rd_mux : '0;
         // Suppress the bank write strobe while its data/address is changing under it.
         odd_hold_q  <= wr & ((word == W_ODD_DAT)  | (word == W_ODD_ADR));
         even_hold_q <= wr & ((word == W_EVEN_DAT) | (word == W_EVEN_ADR));
         if (rd_ack_q) begin
            dbg_q <= rd_dat_q;
         end
         if (wr) begin
            case (word)
               W_BOOT:     boot_addr_q <= merge_lanes(boot_addr_q, wbs_dat_i, wbs_sel_i);
               W_STALL:    if (wbs_sel_i[0]) stall_q   <= wbs_dat_i[0];
               W_RESET:    if (wbs_sel_i[0]) reset_q   <= wbs_dat_i[0];
               W_ODD_DAT:  odd_dat_q <= merge_lanes(odd_dat_q, wbs_dat_i, wbs_sel_i);
               W_ODD_ADR:  odd_adr_q <= odd_adr_nx;
               W_ODD_EN:   if (wbs_sel_i[0]) odd_en_q  <= wbs_dat_i[0];
               W_EVEN_DAT: even_dat_q <= merge_lanes(even_dat_q, wbs_dat_i, wbs_sel_i);
               W_EVEN_ADR: even_adr_q <= even_adr_nx;
               W_EVEN_EN:  if (wbs_sel_i[0]) even_en_q <= wbs_dat_i[0];
               default:    ;
            endcase
         end
      end
   end

   // Reset masks the bus outputs immediately so an ack in flight is cancelled.
   assign wbs_ack_o     = ack_q & ~wb_rst_i;
   assign wbs_dat_o     = wb_rst_i ? '0 : rd_dat_q;
   assign dbg_o         = dbg_q;

   assign boot_addr_o   = boot_addr_q;
   assign stall_o       = stall_q;
   assign core_rst_o    = wb_rst_i | reset_q;
   assign bm_odd_dat_o  = odd_dat_q;
   assign bm_odd_adr_o  = odd_adr_q;
   assign bm_odd_we_o   = odd_en_q & ~odd_hold_q;
   assign bm_even_dat_o = even_dat_q;
   assign bm_even_adr_o = even_adr_q;
   assign bm_even_we_o  = even_en_q & ~even_hold_q;

endmodule
